// File: rtl/jpeg_fdct_pkg.sv
// ---------------------------------------------------------------------------
// jpeg_fdct_pkg
// Shared constants for the 8x8 forward DCT: fixed-point widths, level shift,
// block geometry, FSM state encoding, the MAC loop counter layout and the
// cosine coefficient function used by the ROM.
// ---------------------------------------------------------------------------
package jpeg_fdct_pkg;

  // Fixed-point format of the cosine table and per-pass rounding shift.
  localparam int FRAC_W      = 12;
  localparam int COEF_W_DFLT = 16;
  localparam int ROM_W       = 14;
  localparam int ACC_W       = 32;
  localparam int MID_W       = 16;
  localparam int SMP_W       = 9;

  localparam int         BLK_N       = 64;
  localparam logic [7:0] LEVEL_SHIFT = 8'd128;

  // FSM encoding
  localparam logic [1:0] ST_LOAD = 2'd0;
  localparam logic [1:0] ST_ROW  = 2'd1;
  localparam logic [1:0] ST_COL  = 2'd2;
  localparam logic [1:0] ST_OUT  = 2'd3;

  // MAC loop nest: i is the summation index (innermost), j the output
  // frequency/column, o the outer row.
  typedef struct packed {
    logic [2:0] o;
    logic [2:0] j;
    logic [2:0] i;
  } loop_cnt_t;

  // C[k][n] = round(2^12 * c(k)/2 * cos((2n+1)k*pi/16)), addr = {k,n}.
  // The angle index (2n+1)k is folded mod 32 onto the first quadrant so only
  // eight magnitudes are needed.
  function automatic logic signed [ROM_W-1:0] cos_coef(input logic [5:0] addr);
    logic [2:0]              k;
    logic [2:0]              n;
    logic [4:0]              m;
    logic                    neg;
    logic signed [ROM_W-1:0] mag;
    k   = addr[5:3];
    n   = addr[2:0];
    m   = 5'({n, 1'b1}) * 5'(k);
    neg = 1'b0;
    if (m > 5'd16) m = 5'd0 - m;
    if (m > 5'd8) begin
      neg = 1'b1;
      m   = 5'd16 - m;
    end
    case (m)
      5'd0:    mag = 14'sd2048;
      5'd1:    mag = 14'sd2009;
      5'd2:    mag = 14'sd1892;
      5'd3:    mag = 14'sd1703;
      5'd4:    mag = 14'sd1448;
      5'd5:    mag = 14'sd1138;
      5'd6:    mag = 14'sd784;
      5'd7:    mag = 14'sd400;
      default: mag = 14'sd0;
    endcase
    if (k == 3'd0)
      return 14'sd1448;
    return neg ? -mag : mag;
  endfunction

endpackage

// File: rtl/jpeg_fdct_if.sv
// ---------------------------------------------------------------------------
// jpeg_fdct_if
// Pixel input stream and coefficient output stream of the forward DCT.
//   inport_*  : pixel sample in (valid/accept), raster idx, block id
//   outport_* : coefficient out (valid/accept), raster idx, block id
// Modports: slave = DCT core, master = pixel source / coefficient sink.
// ---------------------------------------------------------------------------
interface jpeg_fdct_if #(
  parameter int COEF_W = jpeg_fdct_pkg::COEF_W_DFLT
);
  logic                     inport_valid_i;
  logic [7:0]               inport_data_i;
  logic [5:0]               inport_idx_i;
  logic [31:0]              inport_id_i;
  logic                     inport_accept_o;
  logic                     outport_valid_o;
  logic signed [COEF_W-1:0] outport_data_o;
  logic [5:0]               outport_idx_o;
  logic [31:0]              outport_id_o;
  logic                     outport_accept_i;

  modport slave (
    input  inport_valid_i, inport_data_i, inport_idx_i, inport_id_i,
    input  outport_accept_i,
    output inport_accept_o,
    output outport_valid_o, outport_data_o, outport_idx_o, outport_id_o
  );

  modport master (
    output inport_valid_i, inport_data_i, inport_idx_i, inport_id_i,
    output outport_accept_i,
    input  inport_accept_o,
    input  outport_valid_o, outport_data_o, outport_idx_o, outport_id_o
  );
endinterface

// File: rtl/jpeg_fdct_rom.sv
// ---------------------------------------------------------------------------
// jpeg_fdct_rom
// Combinational 64-entry cosine lookup.
//   i_addr : {k, n}, frequency k and sample position n
//   o_coef : C[k][n], 14-bit signed, 12 fractional bits
// ---------------------------------------------------------------------------
module jpeg_fdct_rom
  import jpeg_fdct_pkg::*;
(
  input  logic [5:0]              i_addr,
  output logic signed [ROM_W-1:0] o_coef
);

  assign o_coef = cos_coef(i_addr);

endmodule

// File: rtl/jpeg_fdct.sv
// ---------------------------------------------------------------------------
// jpeg_fdct
// 8x8 forward DCT. Loads 64 level-shifted samples, runs a row pass and a
// column pass of one multiply-accumulate per cycle, then streams the 64
// coefficients in raster order.
//   clk_i       : clock
//   rst_i       : asynchronous active-low reset
//   img_start_i : synchronous flush back to LOAD
//   bus         : pixel in / coefficient out streams (slave modport)
// ---------------------------------------------------------------------------
module jpeg_fdct #(
  parameter int COEF_W = jpeg_fdct_pkg::COEF_W_DFLT,
  parameter int FRAC_W = jpeg_fdct_pkg::FRAC_W
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        img_start_i,
  jpeg_fdct_if.slave  bus
);
  import jpeg_fdct_pkg::*;

  localparam logic signed [ACC_W-1:0] RND_BIAS = 32'sd1 <<< (FRAC_W - 1);
  localparam logic signed [ACC_W-1:0] SAT_MAX  = (32'sd1 <<< (COEF_W - 1)) - 32'sd1;
  localparam logic signed [ACC_W-1:0] SAT_MIN  = -(32'sd1 <<< (COEF_W - 1));

  // Control state
  logic [1:0]               r_state;
  loop_cnt_t                r_cnt;
  logic                     r_issue_done;
  logic [31:0]              r_blk_id;

  // MAC pipeline: stage 1 registers the product, stage 2 accumulates
  logic                     r_p_vld;
  logic                     r_p_first;
  logic                     r_p_last;
  logic                     r_p_final;
  logic [5:0]               r_p_dst;
  logic signed [ACC_W-1:0]  r_p_prod;
  logic signed [ACC_W-1:0]  r_acc;

  // Output stage
  logic [5:0]               r_out_idx;
  logic signed [COEF_W-1:0] r_out_data;

  // Block buffers
  logic signed [SMP_W-1:0]  r_smp_mem  [BLK_N];
  logic signed [MID_W-1:0]  r_t_mem    [BLK_N];
  logic signed [COEF_W-1:0] r_coef_mem [BLK_N];

  logic                     w_in_fire;
  logic                     w_busy;
  logic                     w_issue;
  logic                     w_row;
  logic                     w_last_fire;
  logic [5:0]               w_rom_addr;
  logic [5:0]               w_src_addr;
  logic signed [ROM_W-1:0]  w_rom;
  logic signed [MID_W-1:0]  w_src;
  logic signed [ACC_W-1:0]  w_prod;
  logic signed [ACC_W-1:0]  w_acc_sum;
  logic signed [ACC_W-1:0]  w_rnd;
  logic signed [COEF_W-1:0] w_sat;
  logic signed [SMP_W-1:0]  w_smp_in;

  assign w_in_fire = (r_state == ST_LOAD) && bus.inport_valid_i && !img_start_i;
  assign w_row     = (r_state == ST_ROW);
  assign w_busy    = w_row || (r_state == ST_COL);
  assign w_issue   = w_busy && !r_issue_done;
  assign w_smp_in  = SMP_W'({1'b0, bus.inport_data_i}) - SMP_W'(LEVEL_SHIFT);

  // Row pass: s[o][i] * C[j][i] -> T[o][j]
  // Col pass: T[i][j] * C[o][i] -> F[o][j]
  assign w_rom_addr = w_row ? {r_cnt.j, r_cnt.i} : {r_cnt.o, r_cnt.i};
  assign w_src_addr = w_row ? {r_cnt.o, r_cnt.i} : {r_cnt.i, r_cnt.j};
  assign w_src      = w_row ? MID_W'(r_smp_mem[w_src_addr]) : r_t_mem[w_src_addr];

  jpeg_fdct_rom u_rom (
    .i_addr (w_rom_addr),
    .o_coef (w_rom)
  );

  assign w_prod      = ACC_W'(w_src) * ACC_W'(w_rom);
  assign w_acc_sum   = (r_p_first ? '0 : r_acc) + r_p_prod;
  assign w_rnd       = (w_acc_sum + RND_BIAS) >>> FRAC_W;
  assign w_last_fire = r_p_vld && r_p_last;

  // NOTE: every variable written in always_comb gets a default first so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    w_sat = w_rnd[COEF_W-1:0];
    if (w_rnd > SAT_MAX)
      w_sat = SAT_MAX[COEF_W-1:0];
    else if (w_rnd < SAT_MIN)
      w_sat = SAT_MIN[COEF_W-1:0];
  end

  // NOTE: the block buffers have no reset; their contents are always written
  // before being read in a block, and leaving reset off lets them map to RAM.
  always_ff @(posedge clk_i) begin
    if (w_in_fire)
      r_smp_mem[bus.inport_idx_i] <= w_smp_in;
    if (w_last_fire && w_row)
      r_t_mem[r_p_dst] <= w_rnd[MID_W-1:0];
    if (w_last_fire && (r_state == ST_COL))
      r_coef_mem[r_p_dst] <= w_sat;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register sees pre-edge values of the others regardless of block order.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state      <= ST_LOAD;
      r_cnt        <= '0;
      r_issue_done <= 1'b0;
      r_blk_id     <= '0;
      r_p_vld      <= 1'b0;
      r_p_first    <= 1'b0;
      r_p_last     <= 1'b0;
      r_p_final    <= 1'b0;
      r_p_dst      <= '0;
      r_p_prod     <= '0;
      r_acc        <= '0;
      r_out_idx    <= '0;
      r_out_data   <= '0;
    end else if (img_start_i) begin
      // Flush wins over any coincident handshake.
      r_state      <= ST_LOAD;
      r_cnt        <= '0;
      r_issue_done <= 1'b0;
      r_p_vld      <= 1'b0;
      r_out_idx    <= '0;
    end else begin
      r_p_vld <= w_issue;
      if (w_issue) begin
        r_p_first <= (r_cnt.i == 3'd0);
        r_p_last  <= (r_cnt.i == 3'd7);
        r_p_final <= &r_cnt;
        r_p_dst   <= {r_cnt.o, r_cnt.j};
        r_p_prod  <= w_prod;
        r_cnt     <= loop_cnt_t'(r_cnt + 9'd1);
        if (&r_cnt)
          r_issue_done <= 1'b1;
      end
      if (r_p_vld)
        r_acc <= w_acc_sum;

      case (r_state)
        ST_LOAD: begin
          if (w_in_fire && (bus.inport_idx_i == 6'd63)) begin
            r_blk_id <= bus.inport_id_i;
            r_state  <= ST_ROW;
          end
        end
        ST_ROW: begin
          // Advance only once the last accumulate has been written back.
          if (r_p_vld && r_p_final) begin
            r_state      <= ST_COL;
            r_issue_done <= 1'b0;
          end
        end
        ST_COL: begin
          if (r_p_vld && r_p_final) begin
            r_state      <= ST_OUT;
            r_issue_done <= 1'b0;
            r_out_idx    <= '0;
            r_out_data   <= r_coef_mem[0];
          end
        end
        ST_OUT: begin
          if (bus.outport_accept_i) begin
            if (r_out_idx == 6'd63) begin
              r_state   <= ST_LOAD;
              r_out_idx <= '0;
            end else begin
              r_out_idx  <= r_out_idx + 6'd1;
              r_out_data <= r_coef_mem[r_out_idx + 6'd1];
            end
          end
        end
        default: r_state <= ST_LOAD;
      endcase
    end
  end

  assign bus.inport_accept_o = (r_state == ST_LOAD);
  assign bus.outport_valid_o = (r_state == ST_OUT);
  assign bus.outport_data_o  = r_out_data;
  assign bus.outport_idx_o   = r_out_idx;
  assign bus.outport_id_o    = r_blk_id;

endmodule

// File: tb/tb_jpeg_fdct.sv
// ---------------------------------------------------------------------------
// tb_jpeg_fdct
// Directed bench for jpeg_fdct: flat blocks with hand-computed coefficients,
// a random block against a floating-point-derived cosine model, reverse
// load order, stalled output, flush and reset aborts.
// ---------------------------------------------------------------------------
module tb_jpeg_fdct;

  logic clk_i;
  logic rst_i;
  logic img_start_i;

  jpeg_fdct_if #(.COEF_W(16)) bus ();

  jpeg_fdct #(.COEF_W(16), .FRAC_W(12)) u_dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .img_start_i (img_start_i),
    .bus         (bus)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  int n_run;
  int n_fail;
  int pix   [64];
  int exp_q [64];
  int c_tab [8][8];

  task automatic check(input string tag, input longint act, input longint want);
    n_run++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got %0d, want %0d", tag, act, want);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic build_ctab();
    real pi;
    real v;
    pi = 3.14159265358979;
    for (int k = 0; k < 8; k++)
      for (int n = 0; n < 8; n++) begin
        if (k == 0) v = 2048.0 / $sqrt(2.0);
        else        v = 2048.0 * $cos((2 * n + 1) * k * pi / 16.0);
        c_tab[k][n] = (v >= 0.0) ? $rtoi(v + 0.5) : -$rtoi(-v + 0.5);
      end
  endtask

  task automatic run_model();
    int t [64];
    int acc;
    int f;
    for (int y = 0; y < 8; y++)
      for (int u = 0; u < 8; u++) begin
        acc = 0;
        for (int x = 0; x < 8; x++)
          acc += (pix[y * 8 + x] - 128) * c_tab[u][x];
        t[y * 8 + u] = (acc + 2048) >>> 12;
      end
    for (int v = 0; v < 8; v++)
      for (int u = 0; u < 8; u++) begin
        acc = 0;
        for (int y = 0; y < 8; y++)
          acc += t[y * 8 + u] * c_tab[v][y];
        f = (acc + 2048) >>> 12;
        if (f > 32767)  f = 32767;
        if (f < -32768) f = -32768;
        exp_q[v * 8 + u] = f;
      end
  endtask

  task automatic fill(input int val);
    for (int i = 0; i < 64; i++) pix[i] = val;
  endtask

  task automatic set_flat_exp(input int dc);
    for (int i = 0; i < 64; i++) exp_q[i] = 0;
    exp_q[0] = dc;
  endtask

  // rev=1 sends idx 62..0 and then 63, so the block closes on its last beat.
  task automatic load(input logic [31:0] id, input bit rev, input string tag);
    int ix;
    for (int s = 0; s < 64; s++) begin
      ix = rev ? ((s < 63) ? 62 - s : 63) : s;
      if (s == 63) check({tag, "_wait63"}, bus.inport_accept_o, 1);
      bus.inport_valid_i = 1'b1;
      bus.inport_data_i  = 8'(pix[ix]);
      bus.inport_idx_i   = 6'(ix);
      bus.inport_id_i    = id;
      tick();
    end
    bus.inport_valid_i = 1'b0;
  endtask

  task automatic wait_valid(input string tag);
    int guard;
    guard = 0;
    while (!bus.outport_valid_o && guard < 1500) begin
      tick();
      guard++;
    end
    check({tag, "_valid_seen"}, bus.outport_valid_o, 1);
  endtask

  task automatic collect(input logic [31:0] id, input bit stall, input string tag);
    int  k;
    int  guard;
    bit  acc;
    bit  in_acc_busy;
    k           = 0;
    in_acc_busy = 1'b0;
    bus.outport_accept_i = 1'b0;
    guard = 0;
    while (!bus.outport_valid_o && guard < 1500) begin
      if (bus.inport_accept_o) in_acc_busy = 1'b1;
      tick();
      guard++;
    end
    check({tag, "_valid_seen"}, bus.outport_valid_o, 1);
    if (!bus.outport_valid_o) return;
    guard = 0;
    while (k < 64 && guard < 1000) begin
      acc = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      bus.outport_accept_i = acc;
      if (bus.outport_valid_o) begin
        check({tag, "_idx"},  bus.outport_idx_o,  k);
        check({tag, "_data"}, bus.outport_data_o, exp_q[k]);
        check({tag, "_id"},   bus.outport_id_o,   id);
        if (acc) k++;
      end
      if (bus.inport_accept_o && k < 64) in_acc_busy = 1'b1;
      tick();
      guard++;
    end
    bus.outport_accept_i = 1'b0;
    check({tag, "_count"},       k, 64);
    check({tag, "_in_acc_busy"}, in_acc_busy, 0);
    check({tag, "_end_valid"},   bus.outport_valid_o, 0);
    check({tag, "_end_in_acc"},  bus.inport_accept_o, 1);
  endtask

  initial begin
    bit seen;
    n_run  = 0;
    n_fail = 0;
    rst_i       = 1'b1;
    img_start_i = 1'b0;
    bus.inport_valid_i   = 1'b0;
    bus.inport_data_i    = '0;
    bus.inport_idx_i     = '0;
    bus.inport_id_i      = '0;
    bus.outport_accept_i = 1'b0;
    build_ctab();

    // Power-on reset
    #2 rst_i = 1'b0;
    #1;
    check("rst_in_acc", bus.inport_accept_o, 1);
    check("rst_valid",  bus.outport_valid_o, 0);
    check("rst_data",   bus.outport_data_o,  0);
    check("rst_idx",    bus.outport_idx_o,   0);
    check("rst_id",     bus.outport_id_o,    0);
    tick();
    tick();
    rst_i = 1'b1;
    tick();

    // Flat mid-grey: all zero coefficients
    fill(128);
    set_flat_exp(0);
    load(32'h11, 1'b0, "flat128");
    collect(32'h11, 1'b0, "flat128");

    // Flat white: DC = (8*((8*127*1448+2048)>>12)*1448+2048)>>12 = 1015
    fill(255);
    set_flat_exp(1015);
    load(32'h22, 1'b0, "flat255");
    collect(32'h22, 1'b0, "flat255");

    // Flat black: DC = -1024 (floor on negative sums)
    fill(0);
    set_flat_exp(-1024);
    load(32'h23, 1'b0, "flat0");
    collect(32'h23, 1'b0, "flat0");

    // Random block with pseudo-random downstream stalls
    for (int i = 0; i < 64; i++) pix[i] = int'($urandom_range(0, 255));
    run_model();
    load(32'h33, 1'b0, "rand");
    collect(32'h33, 1'b1, "rand");

    // Same data in reverse order, idx 63 last
    load(32'h44, 1'b1, "rev");
    collect(32'h44, 1'b0, "rev");

    // Flush during the column pass: no output for the aborted block
    for (int i = 0; i < 64; i++) pix[i] = int'($urandom_range(0, 255));
    load(32'h55, 1'b0, "flushcol");
    for (int i = 0; i < 700; i++) tick();
    check("flushcol_busy", bus.inport_accept_o, 0);
    img_start_i = 1'b1;
    tick();
    img_start_i = 1'b0;
    check("flushcol_in_acc", bus.inport_accept_o, 1);
    check("flushcol_valid",  bus.outport_valid_o, 0);
    seen = 1'b0;
    for (int i = 0; i < 1200; i++) begin
      if (bus.outport_valid_o) seen = 1'b1;
      tick();
    end
    check("flushcol_no_out", seen, 0);

    // Flush during output with a coincident accept
    fill(128);
    set_flat_exp(0);
    load(32'h66, 1'b0, "flushout");
    wait_valid("flushout");
    bus.outport_accept_i = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    check("flushout_idx3", bus.outport_idx_o, 3);
    img_start_i = 1'b1;
    tick();
    img_start_i = 1'b0;
    bus.outport_accept_i = 1'b0;
    check("flushout_valid",  bus.outport_valid_o, 0);
    check("flushout_idx",    bus.outport_idx_o,   0);
    check("flushout_in_acc", bus.inport_accept_o, 1);

    // Reset during output: valid drops without waiting for a clock edge
    load(32'h77, 1'b0, "rstout");
    wait_valid("rstout");
    bus.outport_accept_i = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    bus.outport_accept_i = 1'b0;
    check("rstout_valid_pre", bus.outport_valid_o, 1);
    #2 rst_i = 1'b0;
    #1;
    check("rstout_valid",  bus.outport_valid_o, 0);
    check("rstout_idx",    bus.outport_idx_o,   0);
    check("rstout_id",     bus.outport_id_o,    0);
    check("rstout_in_acc", bus.inport_accept_o, 1);
    tick();
    rst_i = 1'b1;
    tick();

    // Fresh block after both aborts
    fill(128);
    set_flat_exp(0);
    load(32'h88, 1'b0, "after");
    collect(32'h88, 1'b0, "after");

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
